// File: rtl/coax_pkg.sv
// ============================================================================
// Module      : coax_pkg
// Description : Shared constants, state encoding and width helper for the
//               coax PHY bit timer family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coax_pkg;

   // Default geometry of a coax bit/word
   localparam int COAX_CPB_DEFAULT = 8;
   localparam int COAX_BPW_DEFAULT = 12;

   // Timer run state: idle (counters held at zero) or running
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } coax_state_t;

   // Width of a phase counter covering 0 .. cpb-1 (never narrower than 1 bit)
   function automatic int coax_phase_width(input int cpb);
      return (cpb <= 2) ? 1 : $clog2(cpb);
   endfunction

endpackage

`default_nettype wire

// File: rtl/coax_bit_word_counter.sv
// ============================================================================
// Module      : coax_bit_word_counter
// Description : Bit-within-word counter. Advances on each bit-time wrap,
//               wraps after the last bit of a word, and is held at zero
//               while the timer is idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coax_bit_word_counter
   import coax_pkg::*;
#(
   parameter int BITS_PER_WORD = COAX_BPW_DEFAULT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_clear,
   input  logic                             i_advance,
   output logic [$clog2(BITS_PER_WORD)-1:0] o_bit_index,
   output logic                             o_last_bit
);

   localparam int BW = $clog2(BITS_PER_WORD);
   localparam logic [BW-1:0] c_LAST_BIT = BW'(BITS_PER_WORD - 1);

   logic [BW-1:0] r_bit_index;
   logic          w_last_bit;

   assign w_last_bit  = (r_bit_index == c_LAST_BIT);
   assign o_bit_index = r_bit_index;
   assign o_last_bit  = w_last_bit;

   // Bit index: cleared when idle, stepped (with word wrap) on each bit wrap
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_bit_index <= '0;
      end else if (i_advance) begin
         if (w_last_bit) begin
            r_bit_index <= '0;
         end else begin
            r_bit_index <= r_bit_index + BW'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/coax_sync_bit_timer.sv
// ============================================================================
// Module      : coax_sync_bit_timer
// Description : Parametrised coax bit timer. Produces the mid-bit strobe and
//               half-bit phase flags, counts bits within a word and pulses a
//               word strobe. With COAX_BIT_TIMER_RESYNC_EN defined, observed
//               line transitions near mid-bit re-align the phase; transitions
//               outside the tolerance window raise resync_error. Without the
//               macro the timer free-runs and transition is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coax_sync_bit_timer
   import coax_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = COAX_CPB_DEFAULT,
   parameter int BITS_PER_WORD  = COAX_BPW_DEFAULT,
   parameter int TOLERANCE      = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             transition,
   output logic                             strobe,
   output logic                             first_half,
   output logic                             second_half,
   output logic [$clog2(BITS_PER_WORD)-1:0] bit_index,
   output logic                             word_strobe,
   output logic                             resync_error
);

   localparam int PW   = coax_phase_width(CLOCKS_PER_BIT);
   localparam int BW   = $clog2(BITS_PER_WORD);
   localparam int HALF = CLOCKS_PER_BIT / 2;

   localparam logic [PW-1:0] c_PH_HALF  = PW'(HALF);
   localparam logic [PW-1:0] c_PH_AFTER = PW'(HALF + 1);
   localparam logic [PW-1:0] c_PH_LAST  = PW'(CLOCKS_PER_BIT - 1);

   // Elaboration-time parameter sanity checks
   if ((CLOCKS_PER_BIT < 4) || ((CLOCKS_PER_BIT % 2) != 0)) begin : g_bad_cpb
      $error("coax_sync_bit_timer: CLOCKS_PER_BIT must be even and >= 4");
   end
   if (BITS_PER_WORD < 2) begin : g_bad_bpw
      $error("coax_sync_bit_timer: BITS_PER_WORD must be >= 2");
   end
   if ((TOLERANCE < 0) || (TOLERANCE > (CLOCKS_PER_BIT / 2) - 2)) begin : g_bad_tol
      $error("coax_sync_bit_timer: TOLERANCE must be in 0 .. CLOCKS_PER_BIT/2-2");
   end

   coax_state_t   r_state;
   logic [PW-1:0] r_phase;
   logic          r_strobed;

   logic          w_running;
   logic          w_phase_wrap;
   logic          w_accepted;
   logic          w_resync_error;
   logic          w_strobe;
   logic          w_last_bit;
   logic          w_clear;
   logic [BW-1:0] w_bit_index;

   assign w_running    = (r_state == ST_RUN);
   assign w_phase_wrap = w_running && (r_phase == c_PH_LAST);

`ifdef COAX_BIT_TIMER_RESYNC_EN
   // The window never reaches phase 0 or the last phase, so an accept can
   // never collide with a bit wrap.
   localparam logic [PW-1:0] c_WIN_LO = PW'(HALF - TOLERANCE);
   localparam logic [PW-1:0] c_WIN_HI = PW'(HALF + TOLERANCE);

   logic w_in_window;

   assign w_in_window    = (r_phase >= c_WIN_LO) && (r_phase <= c_WIN_HI);
   assign w_accepted     = transition && w_running && w_in_window;
   assign w_resync_error = transition && w_running && !w_in_window;
`else
   logic w_unused_transition;

   assign w_unused_transition = transition;
   assign w_accepted          = 1'b0;
   assign w_resync_error      = 1'b0;
`endif

   // An early accept pulls the strobe forward; a late one finds r_strobed
   // already set, so each bit time sees exactly one strobe.
   assign w_strobe = w_running && !r_strobed && ((r_phase == c_PH_HALF) || w_accepted);

   // Run state, phase counter and strobe-given flag
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_state   <= ST_IDLE;
         r_phase   <= '0;
         r_strobed <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state   <= ST_RUN;
               r_phase   <= '0;
               r_strobed <= 1'b0;
            end
            ST_RUN: begin
               if (w_accepted) begin
                  // Re-align: the line says mid-bit is now, continue just past it
                  r_phase   <= c_PH_AFTER;
                  r_strobed <= 1'b1;
               end else if (r_phase == c_PH_LAST) begin
                  r_phase   <= '0;
                  r_strobed <= 1'b0;
               end else begin
                  r_phase   <= r_phase + PW'(1);
                  r_strobed <= r_strobed || w_strobe;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_phase   <= '0;
               r_strobed <= 1'b0;
            end
         endcase
      end
   end

   // Counter is cleared whenever the timer is, or is about to be, idle
   assign w_clear = !enable || !w_running;

   coax_bit_word_counter #(
      .BITS_PER_WORD (BITS_PER_WORD)
   ) u_bit_word_counter (
      .clk         (clk),
      .rst         (reset),
      .i_clear     (w_clear),
      .i_advance   (w_phase_wrap),
      .o_bit_index (w_bit_index),
      .o_last_bit  (w_last_bit)
   );

   assign strobe       = w_strobe;
   assign first_half   = w_running && (r_phase <  c_PH_HALF);
   assign second_half  = w_running && (r_phase >= c_PH_HALF);
   assign bit_index    = w_bit_index;
   assign word_strobe  = w_phase_wrap && w_last_bit;
   assign resync_error = w_resync_error;

endmodule

`default_nettype wire

// File: tb/tb_coax_sync_bit_timer.sv
// ============================================================================
// Module      : tb_coax_sync_bit_timer
// Description : Self-checking bench for coax_sync_bit_timer (CPB=8, BPW=4,
//               TOL=1). A reference model pushes expected outputs per cycle
//               to a scoreboard queue; scenario tasks add targeted checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coax_sync_bit_timer;

   localparam int CPB = 8;
   localparam int BPW = 4;
   localparam int TOL = 1;
   localparam int H   = CPB / 2;
   localparam int BW  = $clog2(BPW);
`ifdef COAX_BIT_TIMER_RESYNC_EN
   localparam bit RESYNC = 1'b1;
`else
   localparam bit RESYNC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          transition = 1'b0;
   logic          strobe;
   logic          first_half;
   logic          second_half;
   logic [BW-1:0] bit_index;
   logic          word_strobe;
   logic          resync_error;

   always #5 clk = ~clk;

   coax_sync_bit_timer #(
      .CLOCKS_PER_BIT (CPB),
      .BITS_PER_WORD  (BPW),
      .TOLERANCE      (TOL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .transition   (transition),
      .strobe       (strobe),
      .first_half   (first_half),
      .second_half  (second_half),
      .bit_index    (bit_index),
      .word_strobe  (word_strobe),
      .resync_error (resync_error)
   );

   typedef struct packed {
      logic          strobe;
      logic          fh;
      logic          sh;
      logic          ws;
      logic          rerr;
      logic [BW-1:0] bidx;
   } obs_t;

   obs_t q_exp[$];
   obs_t s_obs;
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   bit   m_run = 1'b0;
   int   m_phase = 0;
   int   m_bit = 0;
   bit   m_strobed = 1'b0;

   // One clock of stimulus: drive at negedge, push expected, advance model
   task automatic step(input logic en, input logic tr, input logic rst_i);
      obs_t e;
      bit   acc;
      @(negedge clk);
      reset      = rst_i;
      enable     = en;
      transition = tr;
      #1;
      acc    = RESYNC && tr && m_run && (m_phase >= H - TOL) && (m_phase <= H + TOL);
      e.strobe = m_run && !m_strobed && ((m_phase == H) || acc);
      e.fh     = m_run && (m_phase < H);
      e.sh     = m_run && (m_phase >= H);
      e.ws     = m_run && (m_phase == CPB - 1) && (m_bit == BPW - 1);
      e.rerr   = RESYNC && tr && m_run && !acc;
      e.bidx   = BW'(m_bit);
      q_exp.push_back(e);
      s_obs = {strobe, first_half, second_half, word_strobe, resync_error, bit_index};
      @(posedge clk);
      if (rst_i || !en) begin
         m_run = 1'b0; m_phase = 0; m_bit = 0; m_strobed = 1'b0;
      end else if (!m_run) begin
         m_run = 1'b1; m_phase = 0; m_bit = 0; m_strobed = 1'b0;
      end else if (acc) begin
         m_phase = H + 1; m_strobed = 1'b1;
      end else if (m_phase == CPB - 1) begin
         m_phase = 0; m_strobed = 1'b0; m_bit = (m_bit + 1) % BPW;
      end else begin
         m_phase = m_phase + 1; m_strobed = m_strobed || e.strobe;
      end
   endtask

   task automatic go_idle();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard: pop and compare every expected entry pushed this cycle
   always @(negedge clk) begin
      #2;
      while (q_exp.size() > 0) begin
         obs_t e;
         obs_t a;
         e = q_exp.pop_front();
         a = {strobe, first_half, second_half, word_strobe, resync_error, bit_index};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t actual=%b required=%b (strobe,fh,sh,ws,rerr,bidx)",
                     $time, a, e);
         end
      end
   end

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (s_obs !== '0) begin
         errors++;
         $display("FAIL reset_outputs actual=%b required=0", s_obs);
      end
   endtask

   task automatic test_free_run();
      int first_s = -1, prev_s = -1, first_w = -1, prev_w = -1;
      for (int k = 0; k <= 70; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (s_obs.strobe) begin
            if (first_s < 0) first_s = k;
            else begin
               checks++;
               if (k - prev_s !== CPB) begin
                  errors++;
                  $display("FAIL strobe_period actual=%0d required=%0d", k - prev_s, CPB);
               end
            end
            prev_s = k;
         end
         if (s_obs.ws) begin
            if (first_w < 0) first_w = k;
            else begin
               checks++;
               if (k - prev_w !== CPB * BPW) begin
                  errors++;
                  $display("FAIL word_period actual=%0d required=%0d", k - prev_w, CPB * BPW);
               end
            end
            prev_w = k;
         end
         if (k >= 1 && k <= 8) begin
            checks++;
            if (s_obs.fh !== (k <= 4)) begin
               errors++;
               $display("FAIL first_half k=%0d actual=%b required=%b", k, s_obs.fh, (k <= 4));
            end
         end
         if (k >= 1 && k <= 33 && (k % 8) == 1) begin
            checks++;
            if (s_obs.bidx !== BW'(((k - 1) / 8) % BPW)) begin
               errors++;
               $display("FAIL bit_index k=%0d actual=%0d required=%0d", k, s_obs.bidx,
                        ((k - 1) / 8) % BPW);
            end
         end
      end
      checks++;
      if (first_s !== H + 1) begin
         errors++;
         $display("FAIL first_strobe actual=%0d required=%0d", first_s, H + 1);
      end
      checks++;
      if (first_w !== CPB * BPW) begin
         errors++;
         $display("FAIL first_word_strobe actual=%0d required=%0d", first_w, CPB * BPW);
      end
      go_idle();
   endtask

   task automatic test_early_accept();
      for (int k = 0; k <= 13; k++) begin
         step(1'b1, (k == 4), 1'b0);
         checks++;
         if (s_obs.strobe !== (k == 4 || k == 12) || s_obs.rerr !== 1'b0) begin
            errors++;
            $display("FAIL early_strobe k=%0d actual=%b/%b required=%b/0", k, s_obs.strobe,
                     s_obs.rerr, (k == 4 || k == 12));
         end
         if (k == 5 || k == 7 || k == 8) begin
            checks++;
            if (s_obs.sh !== (k != 8) || s_obs.bidx !== BW'(k == 8)) begin
               errors++;
               $display("FAIL early_phase k=%0d actual sh=%b bidx=%0d", k, s_obs.sh, s_obs.bidx);
            end
         end
      end
      go_idle();
   endtask

   task automatic test_late_accept();
      for (int k = 0; k <= 15; k++) begin
         step(1'b1, (k == 6), 1'b0);
         checks++;
         if (s_obs.strobe !== (k == 5 || k == 14) || s_obs.rerr !== 1'b0) begin
            errors++;
            $display("FAIL late_strobe k=%0d actual=%b/%b required=%b/0", k, s_obs.strobe,
                     s_obs.rerr, (k == 5 || k == 14));
         end
         if (k == 9 || k == 10) begin
            checks++;
            if (s_obs.bidx !== BW'(k == 10)) begin
               errors++;
               $display("FAIL late_bit_length k=%0d actual=%0d required=%0d", k, s_obs.bidx, (k == 10));
            end
         end
      end
      go_idle();
   endtask

   task automatic test_out_of_window();
      for (int k = 0; k <= 14; k++) begin
         step(1'b1, (k == 2), 1'b0);
         checks++;
         if (s_obs.rerr !== (k == 2) || s_obs.strobe !== (k == 5 || k == 13)) begin
            errors++;
            $display("FAIL window_error k=%0d actual=%b/%b required=%b/%b", k, s_obs.rerr,
                     s_obs.strobe, (k == 2), (k == 5 || k == 13));
         end
      end
      go_idle();
   endtask

   task automatic test_no_resync();
      for (int k = 0; k <= 22; k++) begin
         step(1'b1, (k == 2 || k == 4 || k == 10 || k == 12), 1'b0);
         checks++;
         if (s_obs.rerr !== 1'b0 || s_obs.strobe !== (k == 5 || k == 13 || k == 21)) begin
            errors++;
            $display("FAIL free_run_cadence k=%0d actual=%b/%b required=0/%b", k, s_obs.rerr,
                     s_obs.strobe, (k == 5 || k == 13 || k == 21));
         end
      end
      go_idle();
   endtask

   task automatic test_enable_drop();
      for (int k = 0; k <= 24; k++) begin
         step((k < 19), 1'b0, 1'b0);
         if (k == 19) begin
            checks++;
            if (s_obs.bidx !== BW'(2)) begin
               errors++;
               $display("FAIL drop_bit_index actual=%0d required=2", s_obs.bidx);
            end
         end
         if (k >= 20) begin
            checks++;
            if (s_obs !== '0) begin
               errors++;
               $display("FAIL drop_idle k=%0d actual=%b required=0", k, s_obs);
            end
         end
      end
      for (int j = 0; j <= 6; j++) begin
         step(1'b1, 1'b0, 1'b0);
         checks++;
         if (s_obs.strobe !== (j == 5) || (j == 1 && (s_obs.bidx !== '0 || s_obs.fh !== 1'b1))) begin
            errors++;
            $display("FAIL reenable j=%0d actual strobe=%b bidx=%0d fh=%b", j, s_obs.strobe,
                     s_obs.bidx, s_obs.fh);
         end
      end
      go_idle();
   endtask

   task automatic test_reset_mid_word();
      for (int k = 0; k <= 27; k++) begin
         step(1'b1, 1'b0, (k == 20));
         if (k == 21) begin
            checks++;
            if (s_obs !== '0) begin
               errors++;
               $display("FAIL reset_mid_word actual=%b required=0", s_obs);
            end
         end
         if (k >= 22) begin
            checks++;
            if (s_obs.strobe !== (k == 26) || s_obs.bidx !== '0) begin
               errors++;
               $display("FAIL reset_restart k=%0d actual strobe=%b bidx=%0d", k, s_obs.strobe, s_obs.bidx);
            end
         end
      end
      go_idle();
   endtask

   task automatic test_idle_transition();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b0);
         checks++;
         if (s_obs !== '0) begin
            errors++;
            $display("FAIL idle_transition actual=%b required=0", s_obs);
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_free_run();
`ifdef COAX_BIT_TIMER_RESYNC_EN
      test_early_accept();
      test_late_accept();
      test_out_of_window();
`else
      test_no_resync();
`endif
      test_enable_drop();
      test_reset_mid_word();
      test_idle_transition();
      @(negedge clk);
      #3;
      checks++;
      if (q_exp.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q_exp.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
